// File: rtl/pedal_sensor_cond.sv
// Pedal sensor conditioning: cadence pulse synchroniser, per-window edge count
// and a cadence-clocked 1/32 exponential torque average.
module pedal_sensor_cond #(
    parameter int unsigned WIN_W     = 24,
    parameter int unsigned NP_THRESH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cadence_raw,
    input  logic [11:0] torque,
    output logic [11:0] avg_torque,
    output logic [4:0]  cadence,
    output logic        not_pedaling
);

    logic             q1_q, q2_q, q3_q;
    logic [WIN_W-1:0] timer_q;
    logic [4:0]       edge_q, edge_d, edge_inc;
    logic [4:0]       cad_q, cad_d;
    logic             np_q, np_d;
    logic [16:0]      acc_q, acc_d;
    logic [11:0]      avg_q;
    logic             cad_rise;
    logic             win_end;

    assign cad_rise = q2_q & ~q3_q;
    assign win_end  = &timer_q;

    always_comb begin
        edge_inc = edge_q;
        if (cad_rise && (edge_q != 5'd31)) begin
            edge_inc = edge_q + 5'd1;
        end

        edge_d = edge_inc;
        cad_d  = cad_q;
        np_d   = np_q;
        // An edge landing on the closing cycle belongs to the closing window.
        if (win_end) begin
            edge_d = '0;
            cad_d  = edge_inc;
            np_d   = ({27'd0, edge_inc} < NP_THRESH);
        end

        acc_d = acc_q;
        if (np_q) begin
            acc_d = {torque, 5'b0};
        end else if (cad_rise) begin
            acc_d = acc_q - {5'b0, acc_q[16:5]} + {5'b0, torque};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_q    <= 1'b0;
            q2_q    <= 1'b0;
            q3_q    <= 1'b0;
            timer_q <= '0;
            edge_q  <= '0;
            cad_q   <= '0;
            np_q    <= 1'b1;
            acc_q   <= '0;
            avg_q   <= '0;
        end else begin
            q1_q    <= cadence_raw;
            q2_q    <= q1_q;
            q3_q    <= q2_q;
            timer_q <= timer_q + WIN_W'(1);
            edge_q  <= edge_d;
            cad_q   <= cad_d;
            np_q    <= np_d;
            acc_q   <= acc_d;
            avg_q   <= acc_q[16:5];
        end
    end

    assign avg_torque   = avg_q;
    assign cadence      = cad_q;
    assign not_pedaling = np_q;

endmodule

// File: tb/tb_pedal_sensor_cond.sv
// Bench for pedal_sensor_cond: cycle-indexed reference model compared every
// cycle, plus directed scenarios pinned with hand-computed literals.
module tb_pedal_sensor_cond;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cadence_raw;
    logic [11:0] torque;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic        not_pedaling;

    pedal_sensor_cond #(.WIN_W(8), .NP_THRESH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cadence_raw  (cadence_raw),
        .torque       (torque),
        .avg_torque   (avg_torque),
        .cadence      (cadence),
        .not_pedaling (not_pedaling)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model, indexed by clock edge since reset release. A raw level
    // sampled at edge n that is a rise acts on the edge-count/average at edge n+2.
    bit hist[$];
    int m_k   = 0;
    int m_cnt = 0;
    int m_cad = 0;
    int m_np  = 1;
    int m_acc = 0;
    int m_avg = 0;
    int m_upd = 0;
    bit rise;
    int tot;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k   = 0;
            hist.delete();
            m_cnt = 0;
            m_cad = 0;
            m_np  = 1;
            m_acc = 0;
            m_avg = 0;
        end else begin
            rise = (m_k >= 2) && hist[m_k-2] && !((m_k >= 3) && hist[m_k-3]);
            hist.push_back(cadence_raw);
            m_avg = m_acc / 32;
            if (m_np != 0) begin
                m_acc = int'(torque) * 32;
            end else if (rise) begin
                m_acc = m_acc - m_acc / 32 + int'(torque);
                m_upd++;
            end
            tot = m_cnt + int'(rise);
            if (tot > 31) tot = 31;
            if (m_k % 256 == 255) begin
                m_cad = tot;
                m_np  = (tot < 2) ? 1 : 0;
                m_cnt = 0;
            end else begin
                m_cnt = tot;
            end
            m_k++;
        end
    end

    always @(negedge clk) begin
        check("cmp_avg_torque", int'(avg_torque), m_avg);
        check("cmp_cadence", int'(cadence), m_cad);
        check("cmp_not_pedaling", int'(not_pedaling), m_np);
    end

    int wave_per = 0;
    int ph       = 0;

    task automatic tick();
        @(negedge clk);
        if (wave_per > 0) begin
            cadence_raw = (ph < wave_per / 2);
            ph = (ph + 1) % wave_per;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_k(input int tgt);
        int n = 0;
        while (m_k < tgt && n < 2000) begin
            tick();
            n++;
        end
        if (m_k != tgt) begin
            n_checks++;
            $display("FAIL wait_k: reached edge %0d, required %0d", m_k, tgt);
        end
    endtask

    task automatic wait_upd(input int tgt);
        int n = 0;
        while (m_upd < tgt && n < 200) begin
            tick();
            n++;
        end
        if (m_upd != tgt) begin
            n_checks++;
            $display("FAIL wait_upd: reached %0d updates, required %0d", m_upd, tgt);
        end
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while ((m_k % 256) != p && n < 300) begin
            tick();
            n++;
        end
        if ((m_k % 256) != p) begin
            n_checks++;
            $display("FAIL wait_phase: phase %0d, required %0d", m_k % 256, p);
        end
    endtask

    int base;
    int tgt;

    initial begin
        rst_n       = 1'b0;
        cadence_raw = 1'b0;
        torque      = 12'h400;

        // 1: reset, no pedalling
        ticks(3);
        check("rst_avg", int'(avg_torque), 0);
        check("rst_cad", int'(cadence), 0);
        check("rst_np", int'(not_pedaling), 1);
        rst_n = 1'b1;
        ticks(3);
        check("seed_avg", int'(avg_torque), 'h400);
        check("seed_np", int'(not_pedaling), 1);
        check("seed_cad", int'(cadence), 0);

        // 2: 32-cycle square wave -> 8 edges per window
        wave_per = 32;
        ph       = 0;
        wait_k(256);
        check("win1_cad", int'(cadence), 8);
        check("win1_np", int'(not_pedaling), 0);
        wait_k(512);
        check("win2_cad", int'(cadence), 8);

        // 3: torque step, average moves 1/32 per edge
        torque = 12'h800;
        base   = m_upd;
        wait_upd(base + 1);
        tick();
        check("step1_avg", int'(avg_torque), 'h420);
        wait_upd(base + 2);
        tick();
        check("step2_avg", int'(avg_torque), 'h43F);
        ticks(512);
        check("conv_avg", int'(avg_torque > 12'h43F && avg_torque <= 12'h800), 1);

        // 4: 4-cycle period -> 64 edges, saturates at 31
        wave_per = 4;
        ph       = 0;
        wait_k(((m_k / 256) + 2) * 256);
        check("sat_cad", int'(cadence), 31);
        check("sat_np", int'(not_pedaling), 0);

        // 5: edge on the closing cycle, then stop pedalling
        wave_per    = 0;
        cadence_raw = 1'b0;
        wait_k(((m_k / 256) + 1) * 256);
        base     = m_k;
        wave_per = 32;
        ph       = 0;
        ticks(96);
        wave_per    = 0;
        cadence_raw = 1'b0;
        wait_phase(253);
        cadence_raw = 1'b1;
        wait_k(base + 257);
        check("bnd_cad", int'(cadence), 4);
        check("bnd_np", int'(not_pedaling), 0);
        wait_k(base + 513);
        check("stop_cad", int'(cadence), 0);
        check("stop_np", int'(not_pedaling), 1);
        torque = 12'h123;
        ticks(3);
        check("track_avg", int'(avg_torque), 'h123);

        // 6: asynchronous reset mid-window
        torque      = 12'h400;
        cadence_raw = 1'b0;
        wave_per    = 32;
        ph          = 0;
        tgt         = ((m_k / 256) + 2) * 256 + 1;
        wait_k(tgt);
        check("pre_rst_cad", int'(cadence), 8);
        ticks(100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_cad", int'(cadence), 0);
        check("async_np", int'(not_pedaling), 1);
        check("async_avg", int'(avg_torque), 0);
        wave_per    = 0;
        cadence_raw = 1'b0;
        ticks(2);
        rst_n    = 1'b1;
        wave_per = 32;
        ph       = 0;
        wait_k(255);
        check("post_rst_partial_cad", int'(cadence), 0);
        wait_k(256);
        check("post_rst_cad", int'(cadence), 8);
        check("post_rst_np", int'(not_pedaling), 0);

        ticks(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
